// File: rtl/ptp_ts_insert.sv
// ptp_ts_insert
// Transmit-side PTP timestamp insertion. Timestamps arriving on the s_axis_ts
// port are buffered in a small FIFO. The oldest buffered timestamp is written
// into tuser[TS_OFFSET +: TS_WIDTH] of the first beat of each AXI-stream frame.
// A frame start is stalled until a timestamp is available. Beats after the
// first one are never held back by the FIFO.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axis_ts / _valid / _ready   timestamp input (ready = FIFO not full)
//   s_axis_t{data,keep,valid,last,user}, s_axis_tready   frame input
//   m_axis_t{data,keep,valid,last,user}, m_axis_tready   registered frame output
//   ts_fifo_count                 number of timestamps currently buffered
module ptp_ts_insert #(
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int TS_WIDTH      = 96,
  parameter int TS_OFFSET     = 1,
  parameter int USER_WIDTH    = TS_WIDTH+TS_OFFSET,
  parameter int TS_FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic [TS_WIDTH-1:0]                  s_axis_ts,
  input  logic                                 s_axis_ts_valid,
  output logic                                 s_axis_ts_ready,

  input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]                s_axis_tkeep,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  input  logic [USER_WIDTH-1:0]                s_axis_tuser,
  output logic                                 s_axis_tready,

  output logic [DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]                m_axis_tkeep,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  output logic [USER_WIDTH-1:0]                m_axis_tuser,
  input  logic                                 m_axis_tready,

  output logic [$clog2(TS_FIFO_DEPTH):0]       ts_fifo_count
);

  localparam int AW = $clog2(TS_FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [TS_WIDTH-1:0] ts_mem [TS_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic                ts_push;
  logic                ts_pop;

  logic                in_frame;
  logic                accept;
  logic                first_beat;
  logic [USER_WIDTH-1:0] user_next;

  assign full  = (count == CW'(TS_FIFO_DEPTH));
  assign empty = (count == '0);

  // Push is gated by !full only, so a full FIFO refuses a write even when a
  // pop happens in the same cycle.
  assign s_axis_ts_ready = !full;
  assign ts_push         = s_axis_ts_valid && !full;

  // A frame start needs a buffered timestamp; no bypass from s_axis_ts.
  assign s_axis_tready = (m_axis_tready || !m_axis_tvalid) && (in_frame || !empty);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign first_beat    = !in_frame;
  assign ts_pop        = accept && first_beat;

  assign ts_fifo_count = count;

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (ts_push) begin
      ts_mem[wr_ptr] <= s_axis_ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (ts_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (ts_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({ts_push, ts_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame <= 1'b0;
    end else if (accept) begin
      in_frame <= !s_axis_tlast;
    end
  end

  // Only the timestamp field is overwritten; flags below TS_OFFSET and any
  // bits above the field pass through untouched.
  always_comb begin
    user_next = s_axis_tuser;
    if (first_beat) begin
      user_next[TS_OFFSET +: TS_WIDTH] = ts_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tkeep  <= s_axis_tkeep;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tuser  <= user_next;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
